// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain writer: serialises valid/ready bitstream words MSB-first onto ccff_head.
// Optional readback of the previous chain contents is enabled by defining CCFF_READBACK_EN.
module ccff_bitstream_loader #(
  parameter int DATA_W    = 8,
  parameter int CHAIN_LEN = 56
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
`ifdef CCFF_READBACK_EN
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
`endif
  output logic              done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  // Handshake: a word is taken on the prog_clk edge where in_valid && in_ready;
  // in_data must be stable while in_valid is high, in_ready depends only on registers.
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bits;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  rem_after;
  logic [BIT_W-1:0]  load_bits;
  logic              hs;

  // Ready in SHIFT on the last bit of a word lets the next word follow without a bubble.
  assign in_ready = (state == FETCH) ||
                    (state == SHIFT && bits == BIT_W'(1) && remaining > CNT_W'(1));
  assign hs = in_valid && in_ready;

  always_comb begin
    rem_after = (state == SHIFT) ? remaining - CNT_W'(1) : remaining;
    if (int'(rem_after) >= DATA_W) load_bits = BIT_W'(DATA_W);
    else                           load_bits = BIT_W'(rem_after);
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state         <= IDLE;
      shreg         <= '0;
      bits          <= '0;
      remaining     <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done          <= 1'b0;
          ccff_shift_en <= 1'b0;
          if (start) begin
            state     <= FETCH;
            remaining <= CNT_W'(CHAIN_LEN);
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          ccff_shift_en <= 1'b0;
          if (hs) begin
            shreg <= in_data;
            bits  <= load_bits;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          ccff_head     <= shreg[DATA_W-1];
          ccff_shift_en <= 1'b1;
          shreg         <= shreg << 1;
          bits          <= bits - BIT_W'(1);
          remaining     <= remaining - CNT_W'(1);
          if (bits == BIT_W'(1)) begin
            if (hs) begin
              shreg <= in_data;
              bits  <= load_bits;
            end else if (remaining > CNT_W'(1)) begin
              state <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // The last bit enters the chain on this edge, so done lines up with it.
          ccff_shift_en <= 1'b0;
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  logic [DATA_W-1:0] cap;
  logic [DATA_W-1:0] cap_next;
  logic [BIT_W-1:0]  cap_cnt;
  logic [BIT_W-1:0]  cnt_next;

  always_comb begin
    cap_next = DATA_W'({cap, ccff_tail});
    cnt_next = cap_cnt + BIT_W'(1);
  end

  // The edge seen in DONE carries the final bit; a partial word is flushed left-aligned there.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      cap      <= '0;
      cap_cnt  <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (ccff_shift_en) begin
        if (int'(cnt_next) == DATA_W) begin
          rb_data  <= cap_next;
          rb_valid <= 1'b1;
          cap      <= '0;
          cap_cnt  <= '0;
        end else if (state == DONE) begin
          rb_data  <= cap_next << (DATA_W - int'(cnt_next));
          rb_valid <= 1'b1;
          cap      <= '0;
          cap_cnt  <= '0;
        end else begin
          cap     <= cap_next;
          cap_cnt <= cnt_next;
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule
